// File: rtl/mealy_stream_pkg.sv
// Shared types and sizing helpers for the Mealy stream frame controller.
// Chained (uncleared) detector operation is selected with MEALY_STREAM_CHAIN_EN.
package mealy_stream_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLR   = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int WORD_W_DEF = 8;

  // A hit count must represent 0..WORD_W inclusive.
  function automatic int hit_cnt_w(input int word_w);
    return $clog2(word_w + 1);
  endfunction

  localparam int HIT_CNT_W = hit_cnt_w(WORD_W_DEF);

endpackage

// File: rtl/sat_accum.sv
// CNT_W-bit saturating accumulator; a clear in the same cycle as an add wins.
module sat_accum #(
  parameter int CNT_W = 8,
  parameter int ADD_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             add_en,
  input  logic [ADD_W-1:0] add_val,
  output logic [CNT_W-1:0] acc
);

  // One spare bit so the carry out of the add is visible before clamping.
  localparam int SUM_W = ((CNT_W > ADD_W) ? CNT_W : ADD_W) + 1;
  localparam logic [SUM_W-1:0] MAX_SUM = SUM_W'({CNT_W{1'b1}});

  logic [CNT_W-1:0] acc_q;
  logic [CNT_W-1:0] acc_d;
  logic [SUM_W-1:0] sum;

  always_comb begin
    sum   = SUM_W'(acc_q) + SUM_W'(add_val);
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (add_en) begin
      acc_d = (sum > MAX_SUM) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/mealy_stream_ctrl.sv
// Serializes handshaked words MSB-first onto a bit-level Mealy detector and reports per-frame hits.
// Define MEALY_STREAM_CHAIN_EN to keep detector state across frames (clear only when pending).
module mealy_stream_ctrl
  import mealy_stream_pkg::*;
#(
  parameter int  WORD_W = 8,
  parameter int  CNT_W  = 8,
  localparam int HCW    = hit_cnt_w(WORD_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic              j,
  input  logic              w,
  output logic              det_rst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] hit_mask,
  output logic [HCW-1:0]    hit_cnt,
  output logic [CNT_W-1:0]  total,
  input  logic              clr_total
);

  localparam int IDX_W = $clog2(WORD_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);

  state_e            state_q;
  logic [WORD_W-1:0] data_q;
  logic [IDX_W-1:0]  idx_q;
  logic              j_q;
  logic              det_rst_q;
  logic              out_valid_q;
  logic [WORD_W-1:0] hit_mask_q;
  logic [HCW-1:0]    hit_cnt_q;
  logic              use_clr;
  logic              deliver;

`ifdef MEALY_STREAM_CHAIN_EN
  logic clr_pend_q;
  assign use_clr = clr_pend_q;
`else
  assign use_clr = 1'b1;
`endif

  assign in_ready = (state_q == IDLE);
  assign deliver  = out_valid_q & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      data_q      <= '0;
      idx_q       <= '0;
      j_q         <= 1'b0;
      det_rst_q   <= 1'b0;
      out_valid_q <= 1'b0;
      hit_mask_q  <= '0;
      hit_cnt_q   <= '0;
`ifdef MEALY_STREAM_CHAIN_EN
      clr_pend_q  <= 1'b1;
`endif
    end else begin
      det_rst_q <= 1'b0;
`ifdef MEALY_STREAM_CHAIN_EN
      if (clr_total) begin
        clr_pend_q <= 1'b1;
      end else if (state_q == CLR) begin
        clr_pend_q <= 1'b0;
      end
`endif
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            data_q     <= in_data;
            idx_q      <= '0;
            hit_mask_q <= '0;
            hit_cnt_q  <= '0;
            if (use_clr) begin
              state_q   <= CLR;
              det_rst_q <= 1'b1;
              j_q       <= 1'b0;
            end else begin
              state_q <= SHIFT;
              j_q     <= in_data[WORD_W-1];
            end
          end
        end
        CLR: begin
          state_q <= SHIFT;
          j_q     <= data_q[WORD_W-1];
        end
        SHIFT: begin
          // w belongs to the bit currently on j; hits shift in so the first bit ends at the MSB.
          hit_mask_q <= {hit_mask_q[WORD_W-2:0], w};
          hit_cnt_q  <= hit_cnt_q + HCW'(w);
          if (idx_q == LAST_IDX) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            j_q         <= 1'b0;
            idx_q       <= '0;
          end else begin
            idx_q  <= idx_q + IDX_W'(1);
            j_q    <= data_q[WORD_W-2];
            data_q <= data_q << 1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  sat_accum #(
    .CNT_W (CNT_W),
    .ADD_W (HCW)
  ) u_total (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr_total),
    .add_en  (deliver),
    .add_val (hit_cnt_q),
    .acc     (total)
  );

  assign j         = j_q;
  assign det_rst   = det_rst_q;
  assign out_valid = out_valid_q;
  assign hit_mask  = hit_mask_q;
  assign hit_cnt   = hit_cnt_q;

endmodule

// File: tb/tb_mealy_stream_ctrl.sv
// Randomized self-checking bench for mealy_stream_ctrl against a word-level hit model.
// Honours MEALY_STREAM_CHAIN_EN the same way the design does.
module tb_mealy_stream_ctrl;

  localparam int W       = 8;
  localparam int CW      = 2;
  localparam int HCW     = $clog2(W + 1);
  localparam int TOT_MAX = (1 << CW) - 1;
`ifdef MEALY_STREAM_CHAIN_EN
  localparam bit CHAIN = 1'b1;
`else
  localparam bit CHAIN = 1'b0;
`endif

  logic           clk       = 1'b0;
  logic           rst       = 1'b0;
  logic           in_valid  = 1'b0;
  logic           out_ready = 1'b0;
  logic           clr_total = 1'b0;
  logic           w_force   = 1'b0;
  logic [W-1:0]   in_data   = '0;
  logic           in_ready, j, det_rst, out_valid, w, prev_j;
  logic [W-1:0]   hit_mask;
  logic [HCW-1:0] hit_cnt;
  logic [CW-1:0]  total;

  int n_checks = 0;
  int n_err    = 0;

  // Word-level reference state.
  int total_m    = 0;
  bit clr_pend_m = 1'b1;
  bit carry_m    = 1'b0;
  int last_mask  = 0;
  int last_cnt   = 0;

  always #5 clk = ~clk;

  mealy_stream_ctrl #(
    .WORD_W (W),
    .CNT_W  (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .j         (j),
    .w         (w),
    .det_rst   (det_rst),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .hit_mask  (hit_mask),
    .hit_cnt   (hit_cnt),
    .total     (total),
    .clr_total (clr_total)
  );

  // Overlapping "11" detector; it only advances while a frame is being shifted.
  always @(posedge clk or posedge rst) begin
    if (rst) prev_j <= 1'b0;
    else if (det_rst) prev_j <= 1'b0;
    else if (!in_ready && !out_valid) prev_j <= j;
  end
  assign w = w_force | (j & prev_j);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic run_frame(input logic [W-1:0] d, input int bp, input bit clr_hs);
    logic [W-1:0] exp_mask;
    logic [W-1:0] jlog;
    int exp_cnt, exp_lat, lat;
    bit cleared;
    cleared = !CHAIN || clr_pend_m;
    if (cleared) carry_m = 1'b0;
    // Bit i hits when it and the bit shifted just before it are both 1.
    exp_mask = d & ((d >> 1) | (W'(carry_m) << (W - 1)));
    exp_cnt  = $countones(exp_mask);
    exp_lat  = cleared ? W + 2 : W + 1;
    jlog     = '0;
    check("in_ready idle", in_ready, 1);
    in_data  = d;
    in_valid = 1'b1;
    lat      = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) begin
        in_valid = 1'b0;
        check("det_rst pulse", det_rst, cleared);
      end
      if (!out_valid) jlog = {jlog[W-2:0], j};
    end while (!out_valid && lat < 4 * W);
    check("latency", lat, exp_lat);
    if (!out_valid) return;
    check("serial j", jlog, d);
    check("j in done", j, 0);
    check("hit_mask", hit_mask, exp_mask);
    check("hit_cnt", hit_cnt, exp_cnt);
    check("in_ready done", in_ready, 0);
    for (int c = 0; c < bp; c++) begin
      @(posedge clk); #1;
      check("hold out_valid", out_valid, 1);
      check("hold hit_mask", hit_mask, exp_mask);
      check("hold hit_cnt", hit_cnt, exp_cnt);
      check("hold total", total, total_m);
    end
    check("total before handshake", total, total_m);
    if (cleared) clr_pend_m = 1'b0;
    out_ready = 1'b1;
    clr_total = clr_hs;
    @(posedge clk); #1;
    out_ready = 1'b0;
    clr_total = 1'b0;
    if (clr_hs) begin
      total_m    = 0;
      clr_pend_m = 1'b1;
    end else begin
      total_m = (total_m + exp_cnt > TOT_MAX) ? TOT_MAX : total_m + exp_cnt;
    end
    carry_m   = d[0];
    last_mask = exp_mask;
    last_cnt  = exp_cnt;
    check("out_valid drop", out_valid, 0);
    check("total", total, total_m);
    $display("frame data=%02h clr_hs=%0d bp=%0d lat=%0d mask=%02h cnt=%0d total=%0d",
             d, clr_hs, bp, lat, hit_mask, hit_cnt, total);
  endtask

  task automatic idle_clear();
    clr_total = 1'b1;
    @(posedge clk); #1;
    clr_total  = 1'b0;
    total_m    = 0;
    clr_pend_m = 1'b1;
    check("clr_total idle", total, total_m);
    $display("clear total=%0d", total);
  endtask

  task automatic idle_gap(input int n);
    w_force = 1'b1;
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
      check("gap j", j, 0);
      check("gap hit_mask", hit_mask, last_mask);
      check("gap hit_cnt", hit_cnt, last_cnt);
      check("gap total", total, total_m);
    end
    w_force = 1'b0;
    $display("idle gap cycles=%0d mask=%02h total=%0d", n, hit_mask, total);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " j"}, j, 0);
    check({tag, " det_rst"}, det_rst, 0);
    check({tag, " out_valid"}, out_valid, 0);
    check({tag, " hit_mask"}, hit_mask, 0);
    check({tag, " hit_cnt"}, hit_cnt, 0);
    check({tag, " total"}, total, 0);
    check({tag, " in_ready"}, in_ready, 1);
  endtask

  task automatic reset_mid(input logic [W-1:0] d);
    bit cleared;
    cleared  = !CHAIN || clr_pend_m;
    in_data  = d;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat ((cleared ? 1 : 0) + 4) @(posedge clk);
    #3;
    check("busy before reset", in_ready, 0);
    rst = 1'b1;
    #1;
    check_reset_values("mid-frame reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    total_m    = 0;
    clr_pend_m = 1'b1;
    carry_m    = 1'b0;
    last_mask  = 0;
    last_cnt   = 0;
    $display("reset during frame data=%02h", d);
  endtask

  initial begin
    #2 rst = 1'b1;
    #1;
    check_reset_values("reset");
    #4 rst = 1'b0;
    @(posedge clk); #1;

    run_frame(8'h6E, 0, 1'b0);
    idle_clear();
    run_frame(8'h6E, 5, 1'b0);
    run_frame(8'h01, 0, 1'b0);
    run_frame(8'h80, 0, 1'b0);

    idle_clear();
    for (int f = 0; f < 4; f++) run_frame(8'h6E, 0, 1'b0);
    run_frame(8'h6E, 1, 1'b1);

    reset_mid(8'hFF);
    run_frame(8'h03, 0, 1'b0);
    idle_gap(20);

    for (int f = 0; f < 40; f++) begin
      int g;
      g = int'($urandom_range(0, 2));
      repeat (g) begin
        @(posedge clk); #1;
      end
      if ($urandom_range(0, 4) == 0) idle_clear();
      run_frame(W'($urandom), int'($urandom_range(0, 3)), $urandom_range(0, 5) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mealy_stream_ctrl.md
Name: mealy_stream_ctrl

Overview:
Frame controller for the single-bit Mealy sequence detector. It accepts parallel words over a valid/ready handshake and serializes each word MSB-first onto the detector input `j`. On the same cycles it samples the detector's Mealy output `w` and reports a per-bit hit mask and hit count per frame over an output handshake. It also keeps a saturating running total of hits. It sits between the word-level producer/consumer and the bit-level detector instance.

Parameters:
WORD_W, 8, bits per frame (must be ≥ 2)
CNT_W, 8, width of the running total counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  producer has a frame
in_ready  out  1  controller can accept a frame
in_data  in  WORD_W  frame bits, MSB shifted first
j  out  1  registered serial bit to the detector
w  in  1  detector Mealy output, combinational from j and detector state
det_rst  out  1  registered one-cycle clear pulse to the detector
out_valid  out  1  frame result available
out_ready  in  1  consumer accepts the result
hit_mask  out  WORD_W  bit i set if w=1 while in_data[i] was on j
hit_cnt  out  $clog2(WORD_W+1)  popcount of hit_mask
total  out  CNT_W  saturating sum of hit_cnt over delivered frames
clr_total  in  1  synchronous clear of total

Behaviour:
- Reset (async, rst=1): state=IDLE, j=0, det_rst=0, out_valid=0, hit_mask=0, hit_cnt=0, total=0, shift register=0, bit index=0, clr_pend=1.
- States: IDLE, CLR, SHIFT, DONE.
- in_ready = (state==IDLE). Accept on in_valid&&in_ready at an edge: latch in_data, clear hit_mask and hit_cnt.
- From IDLE on accept: go to CLR, or straight to SHIFT when CLR is skipped (see Optional Feature).
- CLR, one cycle: det_rst=1, j=0. Next state SHIFT.
- SHIFT, exactly WORD_W cycles: on cycle k (0..WORD_W-1), j=data[WORD_W-1-k].
  - At the closing edge of cycle k, if w=1, set hit_mask[WORD_W-1-k] and increment hit_cnt.
  - After the last bit, go to DONE.
- DONE: out_valid=1; hit_mask and hit_cnt are held stable while out_valid && !out_ready.
  - On out_ready: total += hit_cnt, saturating at 2^CNT_W-1. Then out_valid=0 and state returns to IDLE.
- Latency from accept edge to out_valid: WORD_W+2 cycles with CLR, WORD_W+1 without. Minimum spacing between frames is one IDLE cycle.
- In IDLE and DONE: j=0, det_rst=0, and w is ignored.
- clr_total: total=0 at the next edge. If it coincides with a DONE handshake, the clear wins and that frame's hit_cnt is discarded. It also sets clr_pend.
- Arithmetic: hit_cnt never exceeds WORD_W. total is held at its maximum once saturated.
- rst asserted mid-frame: the frame is aborted immediately to the reset values and no result is emitted.

Optional Feature:
Macro: MEALY_STREAM_CHAIN_EN
- Defined: the detector is not cleared between frames, so patterns spanning word boundaries are detected. CLR is entered only when clr_pend=1; clr_pend is then cleared on CLR exit.
- Undefined: every frame passes through CLR, and clr_pend is unused.

Decomposition:
- Package mealy_stream_pkg holds the state enum typedef (IDLE/CLR/SHIFT/DONE) and the localparam for the hit_cnt width, $clog2(WORD_W+1).
- One sub-module, sat_accum: a CNT_W-bit saturating accumulator with clear (inputs add_en, add_val, clr; clear has priority).

Test Plan:
The bench drives `w` from a behavioural overlapping "11" Mealy detector: w = j & prev_j, with prev cleared by det_rst or rst.
1. Basic frame: in_data=8'h6E, out_ready=1 → j sequence 0,1,1,0,1,1,1,0; out_valid 10 cycles after accept; hit_mask=8'h26, hit_cnt=3, total=3.
2. Back-pressure: out_ready=0 for 5 cycles in DONE → out_valid, hit_mask, hit_cnt held; in_ready=0; total unchanged until the handshake.
3. Frame boundary: 8'h01 then 8'h80.
   - Undefined macro: second frame hit_mask=8'h00.
   - MEALY_STREAM_CHAIN_EN: second frame hit_mask=8'h80, hit_cnt=1, and latency is 9 cycles for the second frame.
4. Saturation: CNT_W=2, four frames of 8'h6E → total goes 3, 3, 3, 3. Then clr_total in the same cycle as the fifth DONE handshake → total=0.
5. Reset mid-SHIFT: assert rst at bit 4 of 8'hFF → all outputs are 0 immediately. A following 8'h03 frame gives hit_mask=8'h01.
6. Idle gap: hold in_valid=0 for 20 cycles with w forced to 1 → hit_mask, hit_cnt and total unchanged; j=0.
